// File: rtl/cmp_sweep_checker.sv
// Sweeps every {a,b} operand pair into an external magnitude comparator,
// checks the returned g/e/l flags, counts mismatches and keeps the first one.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - begin a sweep (accepted only in IDLE or DONE)
//   a_out, b_out       - registered operands driven to the comparator
//   g_in, e_in, l_in   - comparator result flags
//   busy, done, pass   - sweep status
//   err_count          - number of mismatching vectors in this sweep
//   fail_valid         - at least one mismatch recorded
//   first_fail         - {a,b} of the first mismatching vector
module cmp_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               g_in,
    input  logic               e_in,
    input  logic               l_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [2*WIDTH-1:0] first_fail
);

    localparam int VW = 2 * WIDTH;
    // Settle counter runs SETTLE-1 down to 0, so clog2(SETTLE) bits suffice.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [VW:0]   ERR_ONE  = (VW+1)'(1);
    localparam logic [VW-1:0] VEC_ONE  = VW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [VW:0]     r_err;
    logic            r_fail_valid;
    logic [VW-1:0]   r_first_fail;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_mis;

    assign w_a = r_vec[VW-1:WIDTH];
    assign w_b = r_vec[WIDTH-1:0];

    // Any single wrong flag counts, so multi-hot and all-zero responses fail.
    assign w_mis = (g_in != (w_a > w_b))
                 | (e_in != (w_a == w_b))
                 | (l_in != (w_a < w_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_SETTLE;
                        r_vec        <= '0;
                        r_cnt        <= CNT_LOAD;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mis) begin
                        r_err <= r_err + ERR_ONE;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_first_fail <= r_vec;
                        end
                    end
                    if (&r_vec) begin
                        // Last vector: operands hold, results freeze.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SETTLE;
                        r_vec   <= r_vec + VEC_ONE;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_out      = w_a;
    assign b_out      = w_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

endmodule
